butterfly_pipe: RTL and testbench
=================================

// Module: butterfly_pipe
// PURPOSE
//  Pipelined complex radix-2 DIT butterfly for the FFT datapath: X = A + B*W, Y = A - B*W.
//  Generalises the combinational real butterfly with twiddle multiply, per-beat scaling,
//  convergent rounding, overflow detection and valid/ready flow control. One instance per FFT stage.
// PARAMETERS
//  W     12  data width per real/imag component, signed two's complement
//  TW    12  twiddle width per component, signed Q1.(TW-1); -1.0 exact, +1.0 = 2^(TW-1)-1
// PORTS
//  clk         in   1    clock, all logic rising-edge
//  rst         in   1    reset, synchronous, active-high
//  in_valid    in   1    input beat valid
//  in_ready    out  1    block accepts beat this cycle
//  a_re,a_im   in   W    operand A
//  b_re,b_im   in   W    operand B
//  w_re,w_im   in   TW   twiddle
//  mul_en      in   1    1: T = B*W; 0: T = B (twiddle bypass)
//  scale       in   1    1: outputs >>1 with convergent rounding; 0: unscaled
//  out_valid   out  1    output beat valid
//  out_ready   in   1    downstream accepts output
//  x_re,x_im   out  W    A + T
//  y_re,y_im   out  W    A - T
//  ovf         out  1    this output beat clipped/wrapped in any of its 4 components
//  ovf_sticky  out  1    OR of ovf over all beats since reset/clear
//  ovf_clr     in   1    clears ovf_sticky
// BEHAVIOUR
//  - Reset: out_valid=0, all internal valids=0, ovf=0, ovf_sticky=0, x/y=0. in_ready=1 after reset.
//  - Pipeline S1 (input reg) -> S2 (products reg) -> S3 (add/sub/round/clip reg = outputs).
//    Latency 3 cycles from accepted beat to out_valid when never stalled. Throughput 1 beat/clk.
//  - Flow: adv = ~out_valid | out_ready; in_ready = adv (combinational). Beat accepted on
//    in_valid & in_ready. When adv=0 all stages hold; outputs stable while out_valid & ~out_ready.
//    Bubbles propagate as invalid stages; no beat dropped, duplicated or reordered.
//  - mul_en, scale travel with the beat (registered in S1), so mode may change every beat.
//  - Twiddle: Tre = br*wr - bi*wi, Tim = br*wi + bi*wr, full precision W+TW+1 bits, then >>(TW-1)
//    with convergent rounding (round half to even) to W+1 bits. Bypass: T = sign-extended B.
//  - Sum/diff computed W+2 bits. scale=1: >>1 convergent (1.5->2, 2.5->2, -1.5->-2), W+1 bits.
//  - Reduction to W bits: see CONFIGURATION. ovf=1 if any component out of signed W range.
//  - ovf_sticky: set on each output beat with ovf=1 at S3 load; ovf_clr clears; set wins when
//    both in same cycle. ovf valid only with out_valid; held with the beat during stall.
//  - rst mid-stream: all in-flight beats discarded, state as reset on next edge.
// CONFIGURATION
//  BFLY_SAT_EN defined: out-of-range results saturate to +2^(W-1)-1 / -2^(W-1).
//  BFLY_SAT_EN undefined: out-of-range results wrap (keep low W bits). ovf flags identical both ways.
// TESTING (W=12, TW=12)
//  1. mul_en=0,scale=0, A=(100,-50),B=(20,30) -> 3 clk later X=(120,-20), Y=(80,-80), ovf=0.
//  2. mul_en=0,scale=1, A=(3,5),B=(0,0) -> X=(2,2), Y=(2,2); A=(-3,7) -> X=(-2,4).
//  3. mul_en=1, W=(0,-2048), A=(0,0), B=(100,0) -> X=(0,-100), Y=(0,100) exact.
//  4. scale=0, A=(2047,0),B=(2047,0) -> ovf=1, ovf_sticky=1; X_re=2047 with BFLY_SAT_EN, -2 without;
//     ovf_clr pulse -> ovf_sticky=0; clr same cycle as new ovf -> stays 1.
//  5. 8 back-to-back beats, out_ready=0 cycles 4..8 -> in_ready drops when S3 full, outputs held
//     stable, all 8 results appear in order once out_ready=1, none lost.
//  6. rst asserted with 3 beats in flight -> next cycle out_valid=0, ovf_sticky=0, in_ready=1.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Pipelined complex radix-2 DIT butterfly: X = A + B*W, Y = A - B*W.
// Three register stages: S1 input capture, S2 twiddle product (rounded),
// S3 add/sub, optional >>1 scaling, reduction to W bits (registered outputs).
// Optional feature macro: BFLY_SAT_EN. When defined, out-of-range results
// saturate; when undefined they wrap to the low W bits. The ovf flags are
// identical in both builds.
//
// Handshake: a beat moves on in_valid & in_ready; an output beat is taken on
// out_valid & out_ready. The whole pipe advances together when
// adv = ~out_valid | out_ready, and in_ready = adv. When adv is low every
// stage holds, so the outputs stay stable while out_valid & ~out_ready.
module butterfly_pipe #(
  parameter int W  = 12,
  parameter int TW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  a_re,
  input  logic signed [W-1:0]  a_im,
  input  logic signed [W-1:0]  b_re,
  input  logic signed [W-1:0]  b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  input  logic                 mul_en,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  x_re,
  output logic signed [W-1:0]  x_im,
  output logic signed [W-1:0]  y_re,
  output logic signed [W-1:0]  y_im,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam logic [TW-2:0]       TW_HALF = {1'b1, {(TW-2){1'b0}}};
  localparam logic signed [W+1:0] MAX_V   = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MIN_V   = {3'b111, {(W-1){1'b0}}};

  // Shift a full-precision product right by TW-1 with round-half-to-even.
  function automatic logic signed [W:0] rnd_tw(input logic signed [W+TW:0] p);
    logic signed [W+TW:0] q;
    logic [TW-2:0]        rem;
    q   = p >>> (TW-1);
    rem = p[TW-2:0];
    if ((rem > TW_HALF) || ((rem == TW_HALF) && q[0]))
      q = q + (W+TW+1)'(1);
    return q[W:0];
  endfunction

  // Optional >>1 with round-half-to-even, then reduce to W bits.
  // Returns {overflow, value}.
  function automatic logic [W:0] finish(input logic signed [W+1:0] s,
                                        input logic                scl);
    logic signed [W+1:0] q;
    logic signed [W+1:0] r;
    logic                o;
    logic [W-1:0]        v;
    q = s >>> 1;
    if (s[0] && q[0])
      q = q + (W+2)'(1);
    r = scl ? q : s;
    o = (r > MAX_V) || (r < MIN_V);
`ifdef BFLY_SAT_EN
    if (o)
      v = r[W+1] ? MIN_V[W-1:0] : MAX_V[W-1:0];
    else
      v = r[W-1:0];
`else
    v = r[W-1:0];
`endif
    return {o, v};
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // S1 state
  logic                 v1_q, mul1_q, scl1_q;
  logic signed [W-1:0]  a1_re_q, a1_im_q, b1_re_q, b1_im_q;
  logic signed [TW-1:0] w1_re_q, w1_im_q;

  // Capture the accepted beat together with its per-beat mode bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; mul1_q <= 1'b0; scl1_q <= 1'b0;
      a1_re_q <= '0; a1_im_q <= '0; b1_re_q <= '0; b1_im_q <= '0;
      w1_re_q <= '0; w1_im_q <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      mul1_q  <= mul_en;  scl1_q  <= scale;
      a1_re_q <= a_re;    a1_im_q <= a_im;
      b1_re_q <= b_re;    b1_im_q <= b_im;
      w1_re_q <= w_re;    w1_im_q <= w_im;
    end
  end

  // Twiddle multiply in full precision (W+TW+1 bits).
  logic signed [W+TW:0] br_x, bi_x, wr_x, wi_x, pr_re, pr_im;
  logic signed [W:0]    t_re_d, t_im_d;
  assign br_x  = {{(TW+1){b1_re_q[W-1]}}, b1_re_q};
  assign bi_x  = {{(TW+1){b1_im_q[W-1]}}, b1_im_q};
  assign wr_x  = {{(W+1){w1_re_q[TW-1]}}, w1_re_q};
  assign wi_x  = {{(W+1){w1_im_q[TW-1]}}, w1_im_q};
  assign pr_re = br_x * wr_x - bi_x * wi_x;
  assign pr_im = br_x * wi_x + bi_x * wr_x;
  assign t_re_d = mul1_q ? rnd_tw(pr_re) : {b1_re_q[W-1], b1_re_q};
  assign t_im_d = mul1_q ? rnd_tw(pr_im) : {b1_im_q[W-1], b1_im_q};

  // S2 state
  logic                v2_q, scl2_q;
  logic signed [W-1:0] a2_re_q, a2_im_q;
  logic signed [W:0]   t2_re_q, t2_im_q;

  // Register the rounded twiddle product alongside A.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0; scl2_q <= 1'b0;
      a2_re_q <= '0; a2_im_q <= '0; t2_re_q <= '0; t2_im_q <= '0;
    end else if (adv) begin
      v2_q    <= v1_q;    scl2_q  <= scl1_q;
      a2_re_q <= a1_re_q; a2_im_q <= a1_im_q;
      t2_re_q <= t_re_d;  t2_im_q <= t_im_d;
    end
  end

  // Sum/difference at W+2 bits, then scale and reduce.
  logic signed [W+1:0] s_xr, s_xi, s_yr, s_yi;
  logic [W:0]          f_xr, f_xi, f_yr, f_yi;
  logic                ovf_d;
  assign s_xr = {{2{a2_re_q[W-1]}}, a2_re_q} + {t2_re_q[W], t2_re_q};
  assign s_xi = {{2{a2_im_q[W-1]}}, a2_im_q} + {t2_im_q[W], t2_im_q};
  assign s_yr = {{2{a2_re_q[W-1]}}, a2_re_q} - {t2_re_q[W], t2_re_q};
  assign s_yi = {{2{a2_im_q[W-1]}}, a2_im_q} - {t2_im_q[W], t2_im_q};
  assign f_xr = finish(s_xr, scl2_q);
  assign f_xi = finish(s_xi, scl2_q);
  assign f_yr = finish(s_yr, scl2_q);
  assign f_yi = finish(s_yi, scl2_q);
  assign ovf_d = f_xr[W] | f_xi[W] | f_yr[W] | f_yi[W];

  // S3 state
  logic                out_valid_q, ovf_q, sticky_q;
  logic signed [W-1:0] x_re_q, x_im_q, y_re_q, y_im_q;

  // Output stage: load a beat (or a bubble) whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0; ovf_q <= 1'b0;
      x_re_q <= '0; x_im_q <= '0; y_re_q <= '0; y_im_q <= '0;
    end else if (adv) begin
      out_valid_q <= v2_q;
      ovf_q       <= v2_q & ovf_d;
      if (v2_q) begin
        x_re_q <= f_xr[W-1:0]; x_im_q <= f_xi[W-1:0];
        y_re_q <= f_yr[W-1:0]; y_im_q <= f_yi[W-1:0];
      end
    end
  end

  // Sticky overflow: a new overflowing beat wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_q <= 1'b0;
    else if (adv && v2_q && ovf_d)
      sticky_q <= 1'b1;
    else if (ovf_clr)
      sticky_q <= 1'b0;
  end

  assign out_valid  = out_valid_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
  assign x_re = x_re_q;
  assign x_im = x_im_q;
  assign y_re = y_re_q;
  assign y_im = y_im_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe (W=12, TW=12): directed beats, an arithmetic
// model feeding an expected queue, one compare process on every output
// handshake, plus hand-computed literal expectations.
module tb_butterfly_pipe;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, mul_en, scale, ovf_clr;
  logic signed [11:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic in_ready, out_valid, ovf, ovf_sticky;
  logic signed [11:0] x_re, x_im, y_re, y_im;

  int checks = 0;
  int errors = 0;
  bit stall_seen = 1'b0;
  logic [48:0] exp_q[$];

  butterfly_pipe #(.W(12), .TW(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .mul_en(mul_en), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- model ----------------
  // Divide by d (a power of two), rounding half to even.
  function automatic int rne(input int v, input int d);
    int q, r;
    q = v / d;
    r = v - q * d;
    if (r < 0) begin q -= 1; r += d; end
    if ((2 * r > d) || ((2 * r == d) && (q % 2 != 0))) q += 1;
    return q;
  endfunction

  function automatic int wrap_bits(input int v, input int bits);
    int m;
    m = 1 << bits;
    v = v % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  function automatic int reduce(input int v, input bit sc, inout bit o);
    if (sc) v = rne(v, 2);
    if (v > 2047 || v < -2048) o = 1'b1;
`ifdef BFLY_SAT_EN
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
`else
    return wrap_bits(v, 12);
`endif
  endfunction

  function automatic logic [48:0] model(input int ar, ai, br, bi, wr, wi,
                                        input bit me, sc);
    int tr, ti, xr, xi, yr, yi;
    bit o;
    o = 1'b0;
    if (me) begin
      tr = wrap_bits(rne(br * wr - bi * wi, 2048), 13);
      ti = wrap_bits(rne(br * wi + bi * wr, 2048), 13);
    end else begin
      tr = br; ti = bi;
    end
    xr = reduce(ar + tr, sc, o);
    xi = reduce(ai + ti, sc, o);
    yr = reduce(ar - tr, sc, o);
    yi = reduce(ai - ti, sc, o);
    return {o, 12'(xr), 12'(xi), 12'(yr), 12'(yi)};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [48:0] e, cur, prev;
    bit have_prev, pv, pr;
    have_prev = 1'b0; pv = 1'b0; pr = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        have_prev = 1'b0;
        continue;
      end
      cur = {ovf, x_re, x_im, y_re, y_im};
      if (have_prev && pv && !pr) begin
        check("stall_valid_held", int'(out_valid), 1);
        if (cur != prev) begin
          check("stall_data_held", 0, 1);
        end else begin
          check("stall_data_held", 1, 1);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("x_re", int'(x_re), int'($signed(e[47:36])));
          check("x_im", int'(x_im), int'($signed(e[35:24])));
          check("y_re", int'(y_re), int'($signed(e[23:12])));
          check("y_im", int'(y_im), int'($signed(e[11:0])));
          check("ovf", int'(ovf), int'(e[48]));
        end
      end
      pv = out_valid; pr = out_ready; prev = cur; have_prev = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int ar, ai, br, bi, wr, wi, input bit me, sc);
    int n;
    a_re = 12'(ar); a_im = 12'(ai); b_re = 12'(br); b_im = 12'(bi);
    w_re = 12'(wr); w_im = 12'(wi); mul_en = me; scale = sc;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      stall_seen = 1'b1;
      @(negedge clk); #1; n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    else exp_q.push_back(model(ar, ai, br, bi, wr, wi, me, sc));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns the number of falling edges waited.
  task automatic wait_out(output int n);
    n = 0;
    #2;
    while (!out_valid && n < 20) begin
      @(negedge clk); #2; n++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  int tv[8][8] = '{
    '{100, -50, 20, 30, 0, 0, 0, 0},
    '{-700, 300, 500, -250, 1448, -1448, 1, 0},
    '{1000, 1000, 1000, 1000, 0, 0, 0, 0},
    '{3, -3, 5, -5, 0, 0, 0, 1},
    '{0, 0, -2048, 100, 2047, -2048, 1, 1},
    '{-1, 1, 7, -9, 1024, 1024, 1, 0},
    '{2047, -2048, -2048, 2047, 0, 0, 0, 1},
    '{-500, 600, 300, 300, 2047, 0, 1, 1}
  };

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    mul_en = 1'b0; scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_ovf", int'(ovf), 0);
    check("rst_sticky", int'(ovf_sticky), 0);
    check("rst_x_re", int'(x_re), 0);
    @(negedge clk);

    // Bypass add/sub and latency
    send(100, -50, 20, 30, 0, 0, 1'b0, 1'b0);
    wait_out(lat);
    check("latency", lat, 2);
    check("t1_x_re", int'(x_re), 120);
    check("t1_x_im", int'(x_im), -20);
    check("t1_y_re", int'(y_re), 80);
    check("t1_y_im", int'(y_im), -80);
    check("t1_ovf", int'(ovf), 0);
    @(negedge clk);

    // Scaling with convergent rounding
    send(3, 5, 0, 0, 0, 0, 1'b0, 1'b1);
    send(-3, 7, 0, 0, 0, 0, 1'b0, 1'b1);
    wait_out(lat);
    check("t2a_x_re", int'(x_re), 2);
    check("t2a_x_im", int'(x_im), 2);
    check("t2a_y_re", int'(y_re), 2);
    @(negedge clk); #2;
    check("t2b_x_re", int'(x_re), -2);
    check("t2b_x_im", int'(x_im), 4);
    @(negedge clk);

    // Twiddle multiply by -j, and twiddle rounding to even
    send(0, 0, 100, 0, 0, -2048, 1'b1, 1'b0);
    send(0, 0, 3, 0, 1024, 0, 1'b1, 1'b0);
    send(0, 0, 5, 0, 1024, 0, 1'b1, 1'b0);
    wait_out(lat);
    check("t3_x_re", int'(x_re), 0);
    check("t3_x_im", int'(x_im), -100);
    check("t3_y_re", int'(y_re), 0);
    check("t3_y_im", int'(y_im), 100);
    @(negedge clk); #2;
    check("tw_1p5_x_re", int'(x_re), 2);
    check("tw_1p5_y_re", int'(y_re), -2);
    @(negedge clk); #2;
    check("tw_2p5_x_re", int'(x_re), 2);
    @(negedge clk);
    drain();

    // Overflow, sticky flag and clear
    send(2047, 0, 2047, 0, 0, 0, 1'b0, 1'b0);
    wait_out(lat);
    check("t4_ovf", int'(ovf), 1);
    check("t4_sticky", int'(ovf_sticky), 1);
`ifdef BFLY_SAT_EN
    check("t4_x_re", int'(x_re), 2047);
`else
    check("t4_x_re", int'(x_re), -2);
`endif
    check("t4_y_re", int'(y_re), 0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #2;
    check("t4_clr", int'(ovf_sticky), 0);
    @(negedge clk);
    send(-2048, 0, 2047, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #2;
    check("t4_set_wins", int'(ovf_sticky), 1);
    check("t4b_ovf", int'(ovf), 1);
`ifdef BFLY_SAT_EN
    check("t4b_y_re", int'(y_re), -2048);
`else
    check("t4b_y_re", int'(y_re), 1);
`endif
    @(negedge clk);
    drain();

    // Back-pressure: 8 back-to-back beats, out_ready low for cycles 4..8
    stall_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5],
               tv[i][6] != 0, tv[i][7] != 0);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 4 && c <= 8);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    check("in_ready_dropped", int'(stall_seen), 1);
    drain();

    // Reset with beats in flight
    send(1000, 1000, 1000, 1000, 0, 0, 1'b0, 1'b0);
    send(1000, 1000, 1000, 1000, 0, 0, 1'b0, 1'b0);
    send(1000, 1000, 1000, 1000, 0, 0, 1'b0, 1'b0);
    #1;
    check("t6_sticky_before", int'(ovf_sticky), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #2;
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_sticky", int'(ovf_sticky), 0);
    check("t6_in_ready", int'(in_ready), 1);
    check("t6_ovf", int'(ovf), 0);
    check("t6_x_re", int'(x_re), 0);
    repeat (4) @(negedge clk);
    check("t6_no_ghost", int'(out_valid), 0);

    // Pipe still works after reset
    send(100, -50, 20, 30, 0, 0, 1'b0, 1'b0);
    wait_out(lat);
    check("t6_after_x_re", int'(x_re), 120);
    @(negedge clk);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
